// File: rtl/core_run_monitor.sv
// core_run_monitor: holds the core in reset, folds each retired instruction into a
// 32-bit signature, detects the PC self-loop halt and reports pass/fail. Optional macro: RUN_TIMEOUT_EN.
module core_run_monitor #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned HALT_REPEAT  = 3,
  parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000,
  parameter int unsigned MAX_CYCLES   = 1024
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Inst,
  input  logic [31:0] PC,
  input  logic [31:0] Result,
  input  logic [31:0] B_data,
  output logic        Core_Reset,
  output logic        Running,
  output logic        Done,
  output logic        Pass,
  output logic        Timeout,
  output logic [31:0] Signature,
  output logic [15:0] Retired
);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [3:0]  SAME_LAST = 4'(HALT_REPEAT - 1);
  localparam logic [31:0] RUN_LAST  = 32'(MAX_CYCLES - 1);

  function automatic logic [31:0] fold_sig(input logic [31:0] sig, input logic [31:0] inst,
                                           input logic [31:0] result, input logic [31:0] b_data);
    return {sig[30:0], sig[31]} ^ result ^ {b_data[15:0], b_data[31:16]} ^ inst;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  same_cnt_q, same_cnt_d;
  logic        first_q, first_d;
  logic [31:0] prev_pc_q, prev_pc_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] retired_q, retired_d;
  logic        core_reset_q, core_reset_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        retire_s;
  logic        halt_s;
  logic        tmo_hit_s;
  logic        timeout_s;

  // A PC wrap is simply a change, so it retires like any other step.
  assign retire_s = first_q || (PC != prev_pc_q);
  assign halt_s   = !retire_s && (same_cnt_q == SAME_LAST);

  // Next-state and datapath for the run sequencer.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    same_cnt_d   = same_cnt_q;
    first_d      = first_q;
    prev_pc_d    = prev_pc_q;
    sig_d        = sig_q;
    retired_d    = retired_q;
    core_reset_d = core_reset_q;
    running_d    = running_q;
    done_d       = done_q;
    case (state_q)
      ST_RST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          first_d      = 1'b1;
          same_cnt_d   = 4'd0;
          core_reset_d = 1'b0;
          running_d    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        prev_pc_d = PC;
        if (retire_s) begin
          sig_d      = fold_sig(sig_q, Inst, Result, B_data);
          retired_d  = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
          same_cnt_d = 4'd0;
          first_d    = 1'b0;
        end else begin
          same_cnt_d = same_cnt_q + 4'd1;
        end
        if (halt_s || tmo_hit_s) begin
          state_d   = ST_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (Start) begin
          state_d      = ST_RST_HOLD;
          hold_cnt_d   = 8'd0;
          sig_d        = 32'd0;
          retired_d    = 16'd0;
          core_reset_d = 1'b1;
          done_d       = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d      = ST_RST_HOLD;
        hold_cnt_d   = 8'd0;
        core_reset_d = 1'b1;
        running_d    = 1'b0;
        done_d       = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_RST_HOLD;
      hold_cnt_q   <= 8'd0;
      same_cnt_q   <= 4'd0;
      first_q      <= 1'b1;
      prev_pc_q    <= 32'd0;
      sig_q        <= 32'd0;
      retired_q    <= 16'd0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      same_cnt_q   <= same_cnt_d;
      first_q      <= first_d;
      prev_pc_q    <= prev_pc_d;
      sig_q        <= sig_d;
      retired_q    <= retired_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

`ifdef RUN_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        timeout_q, timeout_d;

  assign tmo_hit_s = (state_q == ST_RUN) && (run_cnt_q == RUN_LAST);

  // RUN-cycle limit; a halt on the limit cycle wins over the timeout.
  always_comb begin
    run_cnt_d = run_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        run_cnt_d = run_cnt_q + 32'd1;
        if (tmo_hit_s && !halt_s) begin
          timeout_d = 1'b1;
        end else begin
          timeout_d = timeout_q;
        end
      end
      ST_DONE: begin
        if (Start) begin
          run_cnt_d = 32'd0;
          timeout_d = 1'b0;
        end else begin
          run_cnt_d = run_cnt_q;
        end
      end
      default: begin
        run_cnt_d = run_cnt_q;
        timeout_d = timeout_q;
      end
    endcase
  end

  // Timeout registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      run_cnt_q <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_s = timeout_q;
`else
  logic unused_run_last_s;
  assign unused_run_last_s = ^RUN_LAST;
  assign tmo_hit_s         = 1'b0;
  assign timeout_s         = 1'b0;
`endif

  assign Core_Reset = core_reset_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign Timeout    = timeout_s;
  assign Signature  = sig_q;
  assign Retired    = retired_q;
  assign Pass       = done_q && (sig_q == EXPECTED_SIG) && !timeout_s;

endmodule
